// File: rtl/vector_result_writeback.sv
// vector_result_writeback: collects a functional-unit result stream that
// starts LATENCY cycles after issue and writes it element by element into a
// vector register. The element count gives the chaining reference.
module vector_result_writeback #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_i,
  input  logic [6:0]       i_vl,
  input  logic [WIDTH-1:0] i_fu_result,
  output logic             o_wr_en,
  output logic [2:0]       o_wr_reg,
  output logic [5:0]       o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_busy,
  output logic [6:0]       o_elem_count,
  output logic             o_done,
  output logic             o_conflict
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // With a one-cycle latency element 0 is already valid in cycle 1, so the
  // wait phase is skipped entirely.
  localparam bit         SKIP_WAIT = (LATENCY == 1);
  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);

  state_t           r_state;
  logic [3:0]       r_lat_cnt;    // cycles remaining until element 0 is valid
  logic [6:0]       r_vl;         // clamped vector length of current stream
  logic [6:0]       r_idx;        // next element index to capture (0..64)
  logic [2:0]       r_reg;        // latched destination register
  logic             r_wr_en;
  logic [2:0]       r_wr_reg;
  logic [5:0]       r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_busy;
  logic [6:0]       r_elem_count;
  logic             r_done;
  logic             r_conflict;

  logic [6:0]       w_vl_clamped;

  // Lengths above 64 saturate to a full register.
  assign w_vl_clamped = (i_vl > 7'd64) ? 7'd64 : i_vl;

  // Stream control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= 4'd0;
      r_vl         <= 7'd0;
      r_idx        <= 7'd0;
      r_reg        <= 3'd0;
      r_wr_en      <= 1'b0;
      r_wr_reg     <= 3'd0;
      r_wr_addr    <= 6'd0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_elem_count <= 7'd0;
      r_done       <= 1'b0;
      r_conflict   <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      // A start seen while reserved is dropped and flagged one cycle later.
      r_conflict <= i_start & r_busy;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_elem_count <= 7'd0;
            if (w_vl_clamped == 7'd0) begin
              // Empty stream: nothing to write, just signal completion.
              r_done <= 1'b1;
            end else begin
              r_reg     <= i_i;
              r_vl      <= w_vl_clamped;
              r_idx     <= 7'd0;
              r_busy    <= 1'b1;
              r_lat_cnt <= LAT_LOAD;
              r_state   <= SKIP_WAIT ? WRITE : WAIT;
            end
          end
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (r_idx != r_vl) begin
            // Capture element r_idx; it appears on the write port next cycle.
            r_wr_en      <= 1'b1;
            r_wr_addr    <= r_idx[5:0];
            r_wr_data    <= i_fu_result;
            r_wr_reg     <= r_reg;
            r_idx        <= r_idx + 7'd1;
            r_elem_count <= r_idx + 7'd1;
          end else begin
            // Last write is on the port this cycle; release the unit.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_reg     = r_wr_reg;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_elem_count = r_elem_count;
  assign o_done       = r_done;
  assign o_conflict   = r_conflict;

endmodule

// File: tb/tb_vector_result_writeback.sv
// Bench for vector_result_writeback: directed streams plus random issue
// traffic, checked every cycle against a stream-level timing model.
module tb_vector_result_writeback;

  localparam int L = 4;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [2:0]    i_i = 3'd0;
  logic [6:0]    i_vl = 7'd0;
  logic [W-1:0]  i_fu_result = '0;
  logic          o_wr_en;
  logic [2:0]    o_wr_reg;
  logic [5:0]    o_wr_addr;
  logic [W-1:0]  o_wr_data;
  logic          o_busy;
  logic [6:0]    o_elem_count;
  logic          o_done;
  logic          o_conflict;

  vector_result_writeback #(.LATENCY(L), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_i          (i_i),
    .i_vl         (i_vl),
    .i_fu_result  (i_fu_result),
    .o_wr_en      (o_wr_en),
    .o_wr_reg     (o_wr_reg),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_elem_count (o_elem_count),
    .o_done       (o_done),
    .o_conflict   (o_conflict)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: the current (or last) accepted stream, described by its
  // issue cycle, length and destination; outputs follow from cycle arithmetic.
  logic [63:0] fu_hist [0:8191];
  bit          m_act = 1'b0;
  int          m_s = 0;
  int          m_vl = 0;
  logic [2:0]  m_reg = 3'd0;
  int          m_conf_cyc = -10;
  logic [5:0]  m_addr = 6'd0;
  logic [63:0] m_data = 64'd0;
  logic [2:0]  m_wreg = 3'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return m_act && (m_vl > 0) && (c >= m_s + 1) && (c <= m_s + L + m_vl);
  endfunction

  task automatic check_cycle();
    int  c;
    int  k;
    int  e_cnt;
    bit  e_wr;
    bit  e_done;
    c = cyc;
    e_wr = m_act && (m_vl > 0) && (c >= m_s + L + 1) && (c <= m_s + L + m_vl);
    if (e_wr) begin
      k      = c - m_s - L - 1;
      m_addr = k[5:0];
      m_data = fu_hist[(m_s + L + k) % 8192];
      m_wreg = m_reg;
    end
    if (!m_act) e_done = 1'b0;
    else if (m_vl == 0) e_done = (c == m_s + 1);
    else e_done = (c == m_s + L + m_vl + 1);
    if (!m_act) e_cnt = 0;
    else begin
      e_cnt = c - m_s - L;
      if (e_cnt < 0) e_cnt = 0;
      if (e_cnt > m_vl) e_cnt = m_vl;
    end
    chk("wr_en",    64'(o_wr_en),      64'(e_wr));
    chk("wr_reg",   64'(o_wr_reg),     64'(m_wreg));
    chk("wr_addr",  64'(o_wr_addr),    64'(m_addr));
    chk("wr_data",  o_wr_data,         m_data);
    chk("busy",     64'(o_busy),       64'(m_busy(c)));
    chk("done",     64'(o_done),       64'(e_done));
    chk("conflict", 64'(o_conflict),   64'(m_conf_cyc == c));
    chk("elem_cnt", 64'(o_elem_count), 64'(e_cnt));
    if (e_done)
      $display("stream reg=%0d vl=%0d issued at %0d done at %0d count=%0d",
               m_reg, m_vl, m_s, c, o_elem_count);
  endtask

  // Drive one cycle of inputs, advance one clock and check the outputs.
  task automatic run_cycle(input bit st, input logic [2:0] ii, input logic [6:0] vl,
                           input logic [63:0] fu);
    i_start     = st;
    i_i         = ii;
    i_vl        = vl;
    i_fu_result = fu;
    fu_hist[cyc % 8192] = fu;
    if (st) begin
      if (m_busy(cyc)) begin
        m_conf_cyc = cyc + 1;
      end else begin
        m_act = 1'b1;
        m_s   = cyc;
        m_vl  = (vl > 7'd64) ? 64 : int'(vl);
        m_reg = ii;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    i_start = 1'b0;
    check_cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},    64'(o_wr_en),      64'd0);
    chk({tag, "_wr_reg"},   64'(o_wr_reg),     64'd0);
    chk({tag, "_wr_addr"},  64'(o_wr_addr),    64'd0);
    chk({tag, "_wr_data"},  o_wr_data,         64'd0);
    chk({tag, "_busy"},     64'(o_busy),       64'd0);
    chk({tag, "_done"},     64'(o_done),       64'd0);
    chk({tag, "_conflict"}, 64'(o_conflict),   64'd0);
    chk({tag, "_elem_cnt"}, 64'(o_elem_count), 64'd0);
  endtask

  // Assert reset between clock edges, check the outputs clear at once,
  // hold it over two edges and release away from the clock edge.
  task automatic do_reset();
    i_start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    m_act      = 1'b0;
    m_addr     = 6'd0;
    m_data     = 64'd0;
    m_wreg     = 3'd0;
    m_conf_cyc = -10;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc += 3;
    check_cycle();
    $display("reset applied, resume at cycle %0d", cyc);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] fu;
    logic [6:0]  vl;
    int          r;

    // Power-up reset: outputs must clear before any clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_init");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    check_cycle();

    // Basic stream: reg 5, three elements 0xA/0xB/0xC in relative cycles 4..6.
    run_cycle(1'b1, 3'd5, 7'd3, rnd64());
    for (int j = 1; j <= 11; j++) begin
      fu = (j == 4) ? 64'hA : (j == 5) ? 64'hB : (j == 6) ? 64'hC : rnd64();
      run_cycle(1'b0, 3'd0, 7'd0, fu);
    end

    // Empty stream.
    run_cycle(1'b1, 3'd3, 7'd0, rnd64());
    for (int j = 1; j <= 4; j++) run_cycle(1'b0, 3'd0, 7'd0, rnd64());

    // Full-length stream, then an over-length request that saturates to 64.
    for (int rep = 0; rep < 2; rep++) begin
      run_cycle(1'b1, 3'd7, (rep == 0) ? 7'd64 : 7'd100, rnd64());
      for (int j = 1; j <= 72; j++) begin
        fu = (j >= 4 && j < 68) ? 64'(j - 3) : rnd64();
        run_cycle(1'b0, 3'd0, 7'd0, fu);
      end
    end

    // Conflicting issue in cycle 3, accepted issue in the done cycle 8.
    run_cycle(1'b1, 3'd5, 7'd3, rnd64());
    for (int j = 1; j <= 20; j++) begin
      if (j == 3)      run_cycle(1'b1, 3'd2, 7'd5, rnd64());
      else if (j == 8) run_cycle(1'b1, 3'd1, 7'd2, rnd64());
      else             run_cycle(1'b0, 3'd0, 7'd0, rnd64());
    end

    // Reset in cycle 6 of the basic stream, then a normal stream afterwards.
    run_cycle(1'b1, 3'd5, 7'd3, rnd64());
    for (int j = 1; j <= 5; j++) begin
      fu = (j == 4) ? 64'hA : (j == 5) ? 64'hB : rnd64();
      run_cycle(1'b0, 3'd0, 7'd0, fu);
    end
    do_reset();
    run_cycle(1'b1, 3'd6, 7'd2, rnd64());
    for (int j = 1; j <= 10; j++) run_cycle(1'b0, 3'd0, 7'd0, rnd64());

    // Random issue traffic, including issues while busy and random lengths.
    for (int n = 0; n < 2500; n++) begin
      if (n == 1200) do_reset();
      r = $urandom_range(0, 7);
      case (r)
        0:       vl = 7'd0;
        1:       vl = 7'd1;
        2:       vl = 7'd64;
        3:       vl = 7'($urandom_range(65, 127));
        default: vl = 7'($urandom_range(1, 20));
      endcase
      run_cycle($urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), vl, rnd64());
    end
    for (int j = 0; j < 80; j++) run_cycle(1'b0, 3'd0, 7'd0, rnd64());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
